riscv_lsu: RTL and testbench

Load/store unit between the RISC-V datapath and the data memory port. It generalises the fixed single-cycle word load path to all RV32I load/store widths: byte, halfword and word, signed and unsigned. It talks to memory over a request/acknowledge handshake with wait states and a timeout, and reports misaligned or failed accesses. It sits beside the ALU: the datapath supplies the effective address, stalls on `busy`, and writes `rdata` into the register file when `rsp_valid` is high.

---
 rtl/riscv_lsu_pkg.sv | 60 ++++++
 rtl/riscv_lsu_lane.sv | 47 ++++
 rtl/riscv_lsu.sv | 200 ++++++++++++++++++++
 tb/tb_riscv_lsu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types and decode helpers for the RV32I load/store unit.
// CONFIG_RISCV_LSU_MISALIGN_EN adds the BEAT1 state for word-crossing accesses.
package riscv_lsu_pkg;

  typedef enum logic [2:0] {
    LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
`ifdef CONFIG_RISCV_LSU_MISALIGN_EN
    ST_BEAT1,
`endif
    ST_RESP
  } lsu_state_e;

  // Access size: 0 = byte, 1 = halfword, 2 = word.
  function automatic logic [1:0] op_size(lsu_op_e op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: op_size = 2'd0;
      LSU_LH, LSU_LHU, LSU_SH: op_size = 2'd1;
      default:                 op_size = 2'd2;
    endcase
  endfunction

  function automatic logic op_is_store(lsu_op_e op);
    op_is_store = (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  function automatic logic op_is_signed(lsu_op_e op);
    op_is_signed = (op == LSU_LB) || (op == LSU_LH);
  endfunction

  function automatic logic [3:0] size_mask(logic [1:0] size);
    case (size)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic op_misaligned(lsu_op_e op, logic [1:0] off);
    case (op_size(op))
      2'd0:    op_misaligned = 1'b0;
      2'd1:    op_misaligned = off[0];
      default: op_misaligned = (off != 2'd0);
    endcase
  endfunction

  // True when the access spills into the next word.
  function automatic logic op_crosses(lsu_op_e op, logic [1:0] off);
    case (op_size(op))
      2'd0:    op_crosses = 1'b0;
      2'd1:    op_crosses = (off == 2'd3);
      default: op_crosses = (off != 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_lane.sv
// Combinational lane steering: store byte enables/data across two words,
// and load extraction plus sign/zero extension from a two-word window.
module lsu_lane
  import riscv_lsu_pkg::*;
(
  input  lsu_op_e     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd_lo_i,
  input  logic [31:0] rd_hi_i,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wd_lo_o,
  output logic [31:0] wd_hi_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] wmask;
  logic [31:0] rd_sel;
  logic        sext;

  always_comb begin
    case (op_size(op_i))
      2'd0:    wmask = 32'h0000_00ff;
      2'd1:    wmask = 32'h0000_ffff;
      default: wmask = 32'hffff_ffff;
    endcase
    be_wide = {4'b0000, size_mask(op_size(op_i))} << off_i;
    wd_wide = {32'h0, wdata_i & wmask} << {off_i, 3'b000};
    be_lo_o = be_wide[3:0];
    be_hi_o = be_wide[7:4];
    wd_lo_o = wd_wide[31:0];
    wd_hi_o = wd_wide[63:32];

    // Little-endian window: the low word holds the first addressed byte.
    rd_sel = 32'({rd_hi_i, rd_lo_i} >> {off_i, 3'b000});
    sext   = op_is_signed(op_i);
    case (op_size(op_i))
      2'd0:    rdata_o = {{24{sext & rd_sel[7]}}, rd_sel[7:0]};
      2'd1:    rdata_o = {{16{sext & rd_sel[15]}}, rd_sel[15:0]};
      default: rdata_o = rd_sel;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: request FSM, bus handshake with timeout, response.
// Define CONFIG_RISCV_LSU_MISALIGN_EN to service misaligned accesses in hardware.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  lsu_op_e           op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rd
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e        state_q, state_d;
  lsu_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       rd_lo, rd_hi, lane_rdata, wd_lo;
  logic [3:0]        be_lo;
  logic              misaligned, timed_out;
`ifdef CONFIG_RISCV_LSU_MISALIGN_EN
  logic [31:0]       merge_q, merge_d;
  logic [3:0]        be_hi;
  logic [31:0]       wd_hi;

  assign rd_lo = (state_q == ST_BEAT1) ? merge_q : mem_rd;
  assign rd_hi = (state_q == ST_BEAT1) ? mem_rd : 32'h0;
`else
  assign rd_lo = mem_rd;
  assign rd_hi = 32'h0;
`endif

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  lsu_lane u_lane (
    .op_i    (op_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rd_lo_i (rd_lo),
    .rd_hi_i (rd_hi),
    .be_lo_o (be_lo),
`ifdef CONFIG_RISCV_LSU_MISALIGN_EN
    .be_hi_o (be_hi),
    .wd_hi_o (wd_hi),
`else
    .be_hi_o (),
    .wd_hi_o (),
`endif
    .wd_lo_o (wd_lo),
    .rdata_o (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= LSU_LB;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef CONFIG_RISCV_LSU_MISALIGN_EN
      merge_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef CONFIG_RISCV_LSU_MISALIGN_EN
      merge_q <= merge_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef CONFIG_RISCV_LSU_MISALIGN_EN
    merge_d   = merge_q;
    misaligned = 1'b0;
`else
    misaligned = op_misaligned(op, addr[1:0]);
`endif
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    rdata     = '0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wd    = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = misaligned;
          state_d = misaligned ? ST_RESP : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        // The cycle the counter hits the limit already has mem_req dropped.
        if (timed_out) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          mem_req  = 1'b1;
          mem_we   = op_is_store(op_q);
          mem_be   = be_lo;
          mem_addr = word_addr;
          mem_wd   = op_is_store(op_q) ? wd_lo : 32'h0;
          if (mem_ack) begin
`ifdef CONFIG_RISCV_LSU_MISALIGN_EN
            if (op_crosses(op_q, addr_q[1:0])) begin
              merge_d = mem_rd;
              cnt_d   = '0;
              state_d = ST_BEAT1;
            end else
`endif
            begin
              rdata_d = op_is_store(op_q) ? 32'h0 : lane_rdata;
              state_d = ST_RESP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef CONFIG_RISCV_LSU_MISALIGN_EN
      ST_BEAT1: begin
        if (timed_out) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          mem_req  = 1'b1;
          mem_we   = op_is_store(op_q);
          mem_be   = be_hi;
          mem_addr = word_addr + ADDR_W'(4);
          mem_wd   = op_is_store(op_q) ? wd_hi : 32'h0;
          if (mem_ack) begin
            rdata_d = op_is_store(op_q) ? 32'h0 : lane_rdata;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`endif
      ST_RESP: begin
        rsp_valid = 1'b1;
        rdata     = rdata_q;
        err       = err_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu with a small word memory model.
// Expectations follow CONFIG_RISCV_LSU_MISALIGN_EN when it is defined.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  lsu_op_e     op = LSU_LB;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  int vectorCount = 0;
  int missCount = 0;
  int waitStates = 0;
  int waitCnt = 0;
  logic ackEnable = 1'b1;
  logic [31:0] memArr [0:255];

  riscv_lsu #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid),
    .rdata(rdata), .err(err), .busy(busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_ack(mem_ack), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory model: ack after waitStates stall cycles, reload contents on reset.
  assign mem_ack = mem_req && ackEnable && (waitCnt == waitStates);
  assign mem_rd  = memArr[mem_addr[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      waitCnt     <= 0;
      memArr[64]  <= 32'hdeadbeef;
      memArr[65]  <= 32'hc001c0de;
    end else begin
      waitCnt <= (mem_req && !mem_ack) ? waitCnt + 1 : 0;
      if (mem_ack && mem_we)
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) memArr[mem_addr[9:2]][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one operation and watch the bus until the response pulse.
  task automatic applyStimulus(input lsu_op_e o, input logic [31:0] a, input logic [31:0] w,
                               output logic [31:0] rd, output logic er, output int lat,
                               output int reqCycles, output logic [31:0] firstAddr,
                               output logic [31:0] lastAddr, output logic [3:0] firstBe,
                               output logic [31:0] firstWd, output logic firstWe,
                               output logic busyOk);
    logic done;
    @(negedge clk);
    req_valid = 1'b1; op = o; addr = a; wdata = w;
    @(posedge clk);
    #1 req_valid = 1'b0;
    done = 1'b0; lat = 0; reqCycles = 0; busyOk = 1'b1; rd = '0; er = 1'b0;
    firstAddr = '0; lastAddr = '0; firstBe = '0; firstWd = '0; firstWe = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (!busy) busyOk = 1'b0;
      if (mem_req) begin
        if (reqCycles == 0) begin
          firstAddr = mem_addr; firstBe = mem_be; firstWd = mem_wd; firstWe = mem_we;
        end
        lastAddr = mem_addr;
        reqCycles++;
      end
      if (rsp_valid) begin
        done = 1'b1; lat = k; rd = rdata; er = err;
      end
    end
    if (!done) checkOutput("rsp_bound", 32'd0, 32'd1);
  endtask

  logic [31:0] rd, fa, la, fwd;
  logic [3:0]  fbe;
  logic        er, fwe, bok;
  int          lat, rc;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);

    applyStimulus(LSU_LB, 32'h101, 32'h0, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
    checkOutput("lb_rdata", rd, 32'hffffffbe);
    checkOutput("lb_latency", 32'(lat), 32'd2);
    checkOutput("lb_busy", 32'(bok), 32'd1);
    checkOutput("lb_be", 32'(fbe), 32'b0010);
    applyStimulus(LSU_LBU, 32'h101, 32'h0, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
    checkOutput("lbu_rdata", rd, 32'h000000be);
    applyStimulus(LSU_LH, 32'h102, 32'h0, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
    checkOutput("lh_rdata", rd, 32'hffffdead);
    checkOutput("lh_latency", 32'(lat), 32'd2);
    applyStimulus(LSU_LHU, 32'h102, 32'h0, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
    checkOutput("lhu_rdata", rd, 32'h0000dead);
    checkOutput("lhu_err", 32'(er), 32'd0);

    waitStates = 3;
    applyStimulus(LSU_LW, 32'h100, 32'h0, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
    checkOutput("lw_wait_rdata", rd, 32'hdeadbeef);
    checkOutput("lw_wait_req_cycles", 32'(rc), 32'd4);
    checkOutput("lw_wait_latency", 32'(lat), 32'd5);
    checkOutput("lw_wait_err", 32'(er), 32'd0);
    waitStates = 0;

    applyStimulus(LSU_LW, 32'h102, 32'h0, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
`ifdef CONFIG_RISCV_LSU_MISALIGN_EN
    checkOutput("lw_cross_rdata", rd, 32'hc0dedead);
    checkOutput("lw_cross_err", 32'(er), 32'd0);
    checkOutput("lw_cross_beats", 32'(rc), 32'd2);
    checkOutput("lw_cross_addr0", fa, 32'h100);
    checkOutput("lw_cross_addr1", la, 32'h104);
    checkOutput("lw_cross_latency", 32'(lat), 32'd3);
`else
    checkOutput("lw_mis_err", 32'(er), 32'd1);
    checkOutput("lw_mis_rdata", rd, 32'h0);
    checkOutput("lw_mis_req_cycles", 32'(rc), 32'd0);
    checkOutput("lw_mis_latency", 32'(lat), 32'd1);
`endif

    applyStimulus(LSU_SB, 32'h103, 32'h55, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
    checkOutput("sb_be", 32'(fbe), 32'b1000);
    checkOutput("sb_wd_top", 32'(fwd[31:24]), 32'h55);
    checkOutput("sb_we", 32'(fwe), 32'd1);
    checkOutput("sb_addr", fa, 32'h100);
    checkOutput("sb_rdata", rd, 32'h0);
    applyStimulus(LSU_LW, 32'h100, 32'h0, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
    checkOutput("lw_after_sb", rd, 32'h55adbeef);

    ackEnable = 1'b0;
    applyStimulus(LSU_LW, 32'h100, 32'h0, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
    checkOutput("tmo_req_cycles", 32'(rc), 32'd4);
    checkOutput("tmo_err", 32'(er), 32'd1);
    checkOutput("tmo_rdata", rd, 32'h0);
    checkOutput("tmo_latency", 32'(lat), 32'd6);
    ackEnable = 1'b1;
    applyStimulus(LSU_LW, 32'h104, 32'h0, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
    checkOutput("lw_after_tmo", rd, 32'hc001c0de);
    checkOutput("lw_after_tmo_err", 32'(er), 32'd0);

    // Reset while a beat is stalled waiting for acknowledge.
    ackEnable = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; op = LSU_LW; addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("mid_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    ackEnable = 1'b1;
    applyStimulus(LSU_LW, 32'h100, 32'h0, rd, er, lat, rc, fa, la, fbe, fwd, fwe, bok);
    checkOutput("lw_after_rst", rd, 32'hdeadbeef);
    checkOutput("lw_after_rst_latency", 32'(lat), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got 0x00000000, expected 0x00000001");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
